// File: rtl/dscan_pkg.sv
// dscan_pkg: shared constants and width helpers for the display scanner.
// Optional feature macro: DSCAN_BRIGHT_EN (brightness control).
package dscan_pkg;

  localparam int DIG_MAX  = 16;
  localparam int SLOT_MAX = 256;

  localparam logic [DIG_MAX-1:0] SA_OFF = '1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int t_w(input int slots);
    return clog2(slots);
  endfunction

  function automatic int d_w(input int n);
    return clog2(n);
  endfunction

endpackage

// File: rtl/dscan_slot_timer.sv
// dscan_slot_timer: tick/digit scan counters and frame-wrap strobe.
// Advances only on i_tick; wrap strobe is combinational from state.
module dscan_slot_timer
  import dscan_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SLOT_TICKS = 16,
  localparam int TW = t_w(SLOT_TICKS),
  localparam int DW = d_w(N_DIGITS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_tick,
  output logic [TW-1:0] o_t,
  output logic [DW-1:0] o_d,
  output logic          o_wrap
);

  logic [TW-1:0] r_t;
  logic [DW-1:0] r_d;
  logic          w_t_last;
  logic          w_d_last;

  assign w_t_last = (r_t == TW'(SLOT_TICKS - 1));
  assign w_d_last = (r_d == DW'(N_DIGITS - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_t <= '0;
      r_d <= '0;
    end else if (i_tick) begin
      r_t <= w_t_last ? '0 : r_t + TW'(1);
      if (w_t_last) begin
        r_d <= w_d_last ? '0 : r_d + DW'(1);
      end
    end
  end

  assign o_t    = r_t;
  assign o_d    = r_d;
  assign o_wrap = i_tick & w_t_last & w_d_last;

endmodule

// File: rtl/dscan_mux.sv
// dscan_mux: N-digit multiplexed display scanner with per-frame shadowing.
// Brightness control is built only when DSCAN_BRIGHT_EN is defined.
module dscan_mux
  import dscan_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SEG_W      = 8,
  parameter int SLOT_TICKS = 16,
  localparam int BR_W = clog2(SLOT_TICKS)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic [N_DIGITS*SEG_W-1:0] D,
  input  logic [N_DIGITS-1:0]       DIG_EN,
  input  logic [BR_W-1:0]           BRIGHT,
  output logic [N_DIGITS-1:0]       SA,
  output logic [SEG_W-1:0]          L,
  output logic                      FRAME
);

  localparam int DW = d_w(N_DIGITS);

  logic [BR_W-1:0] w_t;
  logic [DW-1:0]   w_d;
  logic            w_wrap;

  dscan_slot_timer #(
    .N_DIGITS  (N_DIGITS),
    .SLOT_TICKS(SLOT_TICKS)
  ) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .i_tick(ENABLE),
    .o_t   (w_t),
    .o_d   (w_d),
    .o_wrap(w_wrap)
  );

  // Shadows follow inputs through reset so frame 0 shows release data.
  logic                      w_load;
  logic [N_DIGITS*SEG_W-1:0] r_d_sh;
  logic [N_DIGITS-1:0]       r_en_sh;
  logic [BR_W-1:0]           w_br_eff;

  assign w_load = RESET | w_wrap;

  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_d_sh  <= D;
      r_en_sh <= DIG_EN;
    end
  end

`ifdef DSCAN_BRIGHT_EN
  logic [BR_W-1:0] r_br_sh;

  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_br_sh <= BRIGHT;
    end
  end

  assign w_br_eff = r_br_sh;
`else
  logic w_unused_br;

  assign w_unused_br = ^BRIGHT;
  assign w_br_eff    = BR_W'(SLOT_TICKS - 1);
`endif

  logic [SEG_W-1:0]    w_seg;
  logic                w_dig_on;
  logic                w_lit;
  logic [N_DIGITS-1:0] w_sa_sel;
  logic [N_DIGITS-1:0] w_sa_nxt;

  assign w_seg    = r_d_sh[int'(w_d)*SEG_W +: SEG_W];
  assign w_dig_on = r_en_sh[w_d];
  assign w_lit    = (w_t != '0) && (w_t <= w_br_eff) && w_dig_on;
  assign w_sa_sel = ~(N_DIGITS'(1) << w_d);
  assign w_sa_nxt = w_lit ? w_sa_sel : SA_OFF[N_DIGITS-1:0];

  logic [N_DIGITS-1:0] r_sa;
  logic [SEG_W-1:0]    r_l;
  logic                r_frame;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sa    <= SA_OFF[N_DIGITS-1:0];
      r_l     <= '0;
      r_frame <= 1'b0;
    end else begin
      r_sa    <= w_sa_nxt;
      r_frame <= w_wrap;
      if (w_t == '0) begin
        r_l <= w_seg;
      end
    end
  end

  assign SA    = r_sa;
  assign L     = r_l;
  assign FRAME = r_frame;

endmodule
